// File: rtl/wfg_wb_interconnect.sv
// Wishbone B4 classic single-master to NSLV-slave page decoder, one registered transaction at a time.
// Define WFG_WB_TIMEOUT_EN to add an ACCESS timeout that answers with err after TIMEOUT cycles.
module wfg_wb_interconnect #(
  parameter int BUSW      = 32,
  parameter int NSLV      = 4,
  parameter int PAGE_LSB  = 4,
  parameter int BASE_PAGE = 1,
  parameter int TIMEOUT   = 16
) (
  input  logic                   io_wbs_clk,
  input  logic                   io_wbs_rst,
  input  logic [BUSW-1:0]        io_wbs_adr,
  input  logic [BUSW-1:0]        io_wbs_datwr,
  input  logic                   io_wbs_we,
  input  logic                   io_wbs_stb,
  input  logic                   io_wbs_cyc,
  output logic [BUSW-1:0]        io_wbs_datrd,
  output logic                   io_wbs_ack,
  output logic                   io_wbs_err,
  output logic [NSLV-1:0]        s_cyc_o,
  output logic [NSLV-1:0]        s_stb_o,
  output logic                   s_we_o,
  output logic [PAGE_LSB-1:0]    s_adr_o,
  output logic [BUSW-1:0]        s_dat_o,
  input  logic [NSLV-1:0]        s_ack_i,
  input  logic [NSLV*BUSW-1:0]   s_dat_i,
  output logic [BUSW-1:0]        err_adr_o,
  output logic [7:0]             err_cnt_o
);

  localparam int PW = BUSW - PAGE_LSB;
  localparam int SW = (NSLV > 1) ? $clog2(NSLV) : 1;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACCESS = 2'd1,
    ST_RESP   = 2'd2
  } state_t;

  state_t          state_r, next_s;
  logic [PW-1:0]   page_s, rel_s;
  logic            mapped_s;
  logic [SW-1:0]   rel_idx_s, sel_r, sel_next_s;
  logic            sel_ack_s;
  logic [BUSW-1:0] sel_dat_s;
  logic            accept_s, go_ok_s, go_err_s, tmo_hit_s;
  logic [BUSW-1:0] adr_r, dat_r, datrd_r, err_adr_r;
  logic            we_r, ack_r, err_r;
  logic [NSLV-1:0] stb_r;
  logic [7:0]      err_cnt_r;

  // Page decode: slave k owns page BASE_PAGE+k, everything else is unmapped.
  assign page_s     = io_wbs_adr[BUSW-1:PAGE_LSB];
  assign rel_s      = page_s - PW'(BASE_PAGE);
  assign mapped_s   = (page_s >= PW'(BASE_PAGE)) && (rel_s < PW'(NSLV));
  assign rel_idx_s  = rel_s[SW-1:0];
  assign sel_next_s = accept_s ? rel_idx_s : sel_r;
  assign sel_ack_s  = s_ack_i[sel_r];
  assign sel_dat_s  = s_dat_i[int'(sel_r)*BUSW +: BUSW];

`ifdef WFG_WB_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT);
  logic [TW-1:0] tmo_cnt_r;

  assign tmo_hit_s = (tmo_cnt_r == TW'(TIMEOUT-1));

  // Cycles spent waiting in ACCESS; cleared on every entry.
  always_ff @(posedge io_wbs_clk) begin
    if (io_wbs_rst) begin
      tmo_cnt_r <= '0;
    end else if ((state_r == ST_ACCESS) && (next_s == ST_ACCESS)) begin
      tmo_cnt_r <= tmo_cnt_r + TW'(1);
    end else begin
      tmo_cnt_r <= '0;
    end
  end
`else
  assign tmo_hit_s = 1'b0;
`endif

  // State register.
  always_ff @(posedge io_wbs_clk) begin
    if (io_wbs_rst) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= next_s;
    end
  end

  // Next state; a master cyc drop abandons the access even if a slave acks.
  always_comb begin
    next_s   = state_r;
    accept_s = 1'b0;
    go_ok_s  = 1'b0;
    go_err_s = 1'b0;
    case (state_r)
      ST_IDLE: begin
        if (io_wbs_stb && io_wbs_cyc) begin
          accept_s = 1'b1;
          if (mapped_s) begin
            next_s = ST_ACCESS;
          end else begin
            next_s   = ST_RESP;
            go_err_s = 1'b1;
          end
        end else begin
          next_s = ST_IDLE;
        end
      end
      ST_ACCESS: begin
        if (!io_wbs_cyc) begin
          next_s = ST_IDLE;
        end else if (sel_ack_s) begin
          next_s  = ST_RESP;
          go_ok_s = 1'b1;
        end else if (tmo_hit_s) begin
          next_s   = ST_RESP;
          go_err_s = 1'b1;
        end else begin
          next_s = ST_ACCESS;
        end
      end
      ST_RESP: next_s = ST_IDLE;
      default: next_s = ST_IDLE;
    endcase
  end

  // Request latches, slave strobes, response and error bookkeeping.
  always_ff @(posedge io_wbs_clk) begin
    if (io_wbs_rst) begin
      adr_r     <= '0;
      dat_r     <= '0;
      we_r      <= 1'b0;
      sel_r     <= '0;
      ack_r     <= 1'b0;
      err_r     <= 1'b0;
      datrd_r   <= '0;
      stb_r     <= '0;
      err_adr_r <= '0;
      err_cnt_r <= 8'd0;
    end else begin
      if (accept_s) begin
        adr_r <= io_wbs_adr;
        dat_r <= io_wbs_datwr;
        we_r  <= io_wbs_we;
        sel_r <= rel_idx_s;
      end
      ack_r   <= go_ok_s;
      err_r   <= go_err_s;
      datrd_r <= (go_ok_s && !we_r) ? sel_dat_s : '0;
      stb_r   <= (next_s == ST_ACCESS) ? (NSLV'(1) << sel_next_s) : '0;
      if (go_err_s) begin
        err_adr_r <= accept_s ? io_wbs_adr : adr_r;
        if (err_cnt_r != 8'hFF) begin
          err_cnt_r <= err_cnt_r + 8'd1;
        end
      end
    end
  end

  assign io_wbs_ack   = ack_r;
  assign io_wbs_err   = err_r;
  assign io_wbs_datrd = datrd_r;
  assign s_cyc_o      = stb_r;
  assign s_stb_o      = stb_r;
  assign s_we_o       = we_r;
  assign s_adr_o      = adr_r[PAGE_LSB-1:0];
  assign s_dat_o      = dat_r;
  assign err_adr_o    = err_adr_r;
  assign err_cnt_o    = err_cnt_r;

endmodule

// File: tb/tb_wfg_wb_interconnect.sv
// Self-checking bench for wfg_wb_interconnect: directed spec cases plus randomized transactions
// checked against an address-arithmetic reference model and an error-count scoreboard.
`timescale 1ns/1ps
module tb_wfg_wb_interconnect;
  localparam int BUSW = 32, NSLV = 4, PAGE_LSB = 4, BASE_PAGE = 1, TIMEOUT = 16;

  logic                 clk = 1'b0;
  logic                 rst;
  logic [BUSW-1:0]      adr, datwr;
  logic                 we, stb, cyc;
  logic [BUSW-1:0]      datrd;
  logic                 ack, err;
  logic [NSLV-1:0]      s_cyc, s_stb;
  logic                 s_we;
  logic [PAGE_LSB-1:0]  s_adr;
  logic [BUSW-1:0]      s_dat_o;
  logic [NSLV-1:0]      s_ack;
  logic [NSLV*BUSW-1:0] s_dat;
  logic [BUSW-1:0]      err_adr;
  logic [7:0]           err_cnt;

  always #5 clk = ~clk;

  wfg_wb_interconnect #(.BUSW(BUSW), .NSLV(NSLV), .PAGE_LSB(PAGE_LSB), .BASE_PAGE(BASE_PAGE),
                        .TIMEOUT(TIMEOUT)) dut (
    .io_wbs_clk(clk), .io_wbs_rst(rst), .io_wbs_adr(adr), .io_wbs_datwr(datwr),
    .io_wbs_we(we), .io_wbs_stb(stb), .io_wbs_cyc(cyc), .io_wbs_datrd(datrd),
    .io_wbs_ack(ack), .io_wbs_err(err), .s_cyc_o(s_cyc), .s_stb_o(s_stb), .s_we_o(s_we),
    .s_adr_o(s_adr), .s_dat_o(s_dat_o), .s_ack_i(s_ack), .s_dat_i(s_dat),
    .err_adr_o(err_adr), .err_cnt_o(err_cnt)
  );

  int checks = 0, errors = 0;
  int model_cnt = 0;
  logic [BUSW-1:0] model_eadr = '0;

  // results of the last run_txn
  bit              r_ack, r_err, r_both, r_timeout, r_post_clean;
  logic [BUSW-1:0] r_dat, r_sdat;
  logic [NSLV-1:0] r_stb, r_stb_at_resp;
  logic            r_we;
  logic [PAGE_LSB-1:0] r_sadr;
  int              r_lat, r_stb_lat;

  function automatic bit ref_mapped(input logic [BUSW-1:0] a);
    int unsigned page;
    page = a >> PAGE_LSB;
    return (page >= BASE_PAGE) && (page < BASE_PAGE + NSLV);
  endfunction

  function automatic int ref_idx(input logic [BUSW-1:0] a);
    return int'(a >> PAGE_LSB) - BASE_PAGE;
  endfunction

  task automatic model_err(input logic [BUSW-1:0] a);
    model_cnt  = (model_cnt < 255) ? model_cnt + 1 : 255;
    model_eadr = a;
  endtask

  // Master issues one request; behavioural slaves ack the strobed slave after ack_after strobe cycles.
  task automatic run_txn(input logic [BUSW-1:0] a, input bit w, input logic [BUSW-1:0] wd,
                         input int ack_after, input logic [BUSW-1:0] rd, input bit noise,
                         input int budget);
    int first_n;
    r_ack = 0; r_err = 0; r_both = 0; r_timeout = 1; r_dat = '0; r_stb = '0;
    r_stb_at_resp = '0; r_we = 0; r_sadr = '0; r_sdat = '0; r_lat = 0; r_stb_lat = 0;
    first_n = -1;
    @(negedge clk);
    adr = a; datwr = wd; we = w; stb = 1'b1; cyc = 1'b1; s_ack = '0;
    for (int n = 1; n <= budget; n++) begin
      @(negedge clk);
      if (s_stb != '0 && first_n < 0) begin
        first_n = n; r_stb = s_stb; r_we = s_we; r_sadr = s_adr; r_sdat = s_dat_o;
      end
      if (ack || err) begin
        r_ack = ack; r_err = err; r_both = ack && err; r_dat = datrd; r_lat = n;
        r_stb_lat = (first_n < 0) ? 0 : n - first_n; r_stb_at_resp = s_stb; r_timeout = 0;
        break;
      end
      s_ack = noise ? (NSLV'($urandom) & ~s_stb) : '0;
      for (int j = 0; j < NSLV; j++) s_dat[j*BUSW +: BUSW] = $urandom;
      if (s_stb != '0 && first_n >= 0 && (n - first_n + 1) == ack_after) begin
        for (int j = 0; j < NSLV; j++)
          if (s_stb[j]) begin s_ack[j] = 1'b1; s_dat[j*BUSW +: BUSW] = rd; end
      end
    end
    stb = 1'b0; cyc = 1'b0; s_ack = '0;
    @(negedge clk);
    r_post_clean = !ack && !err && (s_stb == '0);
  endtask

  task automatic test_reset();
    rst = 1'b1; adr = 32'h0000_0024; stb = 1'b1; cyc = 1'b1; we = 1'b0; datwr = 32'h1234_5678;
    s_ack = '1; s_dat = '1;
    repeat (3) @(negedge clk);
    checks++; if (ack !== 1'b0 || err !== 1'b0) begin errors++; $display("FAIL reset_resp: ack=%b err=%b expected 0 0", ack, err); end
    checks++; if (datrd !== 32'h0) begin errors++; $display("FAIL reset_datrd: got %h expected 0", datrd); end
    checks++; if (s_stb !== '0 || s_cyc !== '0) begin errors++; $display("FAIL reset_stb: stb=%b cyc=%b expected 0", s_stb, s_cyc); end
    checks++; if (s_we !== 1'b0 || s_adr !== '0 || s_dat_o !== '0) begin errors++; $display("FAIL reset_latch: we=%b adr=%h dat=%h expected 0", s_we, s_adr, s_dat_o); end
    checks++; if (err_adr !== '0 || err_cnt !== 8'd0) begin errors++; $display("FAIL reset_errlog: adr=%h cnt=%0d expected 0 0", err_adr, err_cnt); end
    stb = 1'b0; cyc = 1'b0; s_ack = '0; s_dat = '0;
    @(negedge clk); rst = 1'b0;
    model_cnt = 0; model_eadr = '0;
  endtask

  task automatic test_directed();
    run_txn(32'h0000_0024, 1'b0, 32'h0, 3, 32'hA5A5_0001, 1'b0, 50);
    checks++; if (!r_ack || r_err || r_dat !== 32'hA5A5_0001) begin errors++; $display("FAIL dir_read: ack=%b err=%b dat=%h expected 1 0 a5a50001", r_ack, r_err, r_dat); end
    checks++; if (r_stb !== 4'b0010 || r_sadr !== 4'd4 || r_we !== 1'b0) begin errors++; $display("FAIL dir_read_slave: stb=%b adr=%h we=%b expected 0010 4 0", r_stb, r_sadr, r_we); end
    checks++; if (r_stb_lat !== 3 || !r_post_clean) begin errors++; $display("FAIL dir_read_timing: lat=%0d clean=%b expected 3 1", r_stb_lat, r_post_clean); end
    run_txn(32'h0000_0010, 1'b1, 32'hDEAD_BEEF, 1, 32'hFFFF_FFFF, 1'b0, 50);
    checks++; if (!r_ack || r_err || r_dat !== 32'h0) begin errors++; $display("FAIL dir_write: ack=%b err=%b dat=%h expected 1 0 0", r_ack, r_err, r_dat); end
    checks++; if (r_stb !== 4'b0001 || r_we !== 1'b1 || r_sdat !== 32'hDEAD_BEEF || r_sadr !== 4'd0) begin errors++; $display("FAIL dir_write_slave: stb=%b we=%b dat=%h adr=%h expected 0001 1 deadbeef 0", r_stb, r_we, r_sdat, r_sadr); end
    checks++; if (r_lat !== 2) begin errors++; $display("FAIL dir_min_roundtrip: got %0d expected 2", r_lat); end
    run_txn(32'h0000_0000, 1'b0, 32'h0, 1, 32'h0, 1'b0, 10); model_err(32'h0000_0000);
    checks++; if (!r_err || r_ack || r_lat !== 1 || r_stb !== '0) begin errors++; $display("FAIL dir_unmapped0: err=%b ack=%b lat=%0d stb=%b expected 1 0 1 0", r_err, r_ack, r_lat, r_stb); end
    run_txn(32'h0000_0050, 1'b1, 32'h0, 1, 32'h0, 1'b0, 10); model_err(32'h0000_0050);
    checks++; if (!r_err || r_ack || r_lat !== 1 || r_stb !== '0 || r_dat !== '0) begin errors++; $display("FAIL dir_unmapped50: err=%b ack=%b lat=%0d stb=%b dat=%h expected 1 0 1 0 0", r_err, r_ack, r_lat, r_stb, r_dat); end
    checks++; if (err_adr !== 32'h50 || err_cnt !== 8'd2) begin errors++; $display("FAIL dir_errlog: adr=%h cnt=%0d expected 50 2", err_adr, err_cnt); end
  endtask

  task automatic test_random();
    logic [BUSW-1:0] a, wd, rd;
    bit w;
    int dly;
    for (int i = 0; i < 40; i++) begin
      a  = ($urandom_range(0, 7) == 0) ? BUSW'($urandom) : ((BUSW'($urandom_range(0, 6)) << PAGE_LSB) | BUSW'($urandom_range(0, 15)));
      w  = 1'($urandom_range(0, 1)); wd = $urandom; rd = $urandom; dly = $urandom_range(1, 5);
      run_txn(a, w, wd, dly, rd, 1'b1, 50);
      checks++; if (r_both || !r_post_clean) begin errors++; $display("FAIL rnd_protocol[%0d]: both=%b clean=%b expected 0 1", i, r_both, r_post_clean); end
      if (ref_mapped(a)) begin
        checks++; if (!r_ack || r_err || r_dat !== (w ? '0 : rd) || r_stb_lat !== dly) begin errors++; $display("FAIL rnd_mapped[%0d]: ack=%b err=%b dat=%h lat=%0d expected 1 0 %h %0d", i, r_ack, r_err, r_dat, r_stb_lat, (w ? '0 : rd), dly); end
        checks++; if (r_stb !== (NSLV'(1) << ref_idx(a)) || r_sadr !== a[PAGE_LSB-1:0] || r_we !== w || r_sdat !== wd) begin errors++; $display("FAIL rnd_slave[%0d]: stb=%b adr=%h we=%b dat=%h expected %b %h %b %h", i, r_stb, r_sadr, r_we, r_sdat, NSLV'(1) << ref_idx(a), a[PAGE_LSB-1:0], w, wd); end
      end else begin
        model_err(a);
        checks++; if (!r_err || r_ack || r_lat !== 1 || r_stb !== '0 || r_dat !== '0) begin errors++; $display("FAIL rnd_unmapped[%0d]: err=%b ack=%b lat=%0d stb=%b expected 1 0 1 0", i, r_err, r_ack, r_lat, r_stb); end
      end
      checks++; if (err_adr !== model_eadr || err_cnt !== 8'(model_cnt)) begin errors++; $display("FAIL rnd_errlog[%0d]: adr=%h cnt=%0d expected %h %0d", i, err_adr, err_cnt, model_eadr, model_cnt); end
    end
  endtask

  task automatic test_timeout();
`ifdef WFG_WB_TIMEOUT_EN
    run_txn(32'h0000_0030, 1'b0, 32'h0, -1, 32'h0, 1'b0, 100); model_err(32'h0000_0030);
    checks++; if (r_timeout || !r_err || r_ack || r_stb_lat !== TIMEOUT || r_stb_at_resp !== '0) begin errors++; $display("FAIL timeout: tmo=%b err=%b ack=%b lat=%0d stb=%b expected 0 1 0 %0d 0", r_timeout, r_err, r_ack, r_stb_lat, r_stb_at_resp, TIMEOUT); end
`else
    run_txn(32'h0000_0030, 1'b0, 32'h0, -1, 32'h0, 1'b0, 1000);
    checks++; if (!r_timeout || !r_post_clean) begin errors++; $display("FAIL no_timeout: responded=%b clean=%b expected 0 1", !r_timeout, r_post_clean); end
`endif
    checks++; if (err_adr !== model_eadr || err_cnt !== 8'(model_cnt)) begin errors++; $display("FAIL timeout_errlog: adr=%h cnt=%0d expected %h %0d", err_adr, err_cnt, model_eadr, model_cnt); end
    run_txn(32'h0000_0040, 1'b0, 32'h0, TIMEOUT, 32'h1357_9BDF, 1'b0, 100);
    checks++; if (!r_ack || r_err || r_dat !== 32'h1357_9BDF || r_stb_lat !== TIMEOUT) begin errors++; $display("FAIL ack_vs_timeout: ack=%b err=%b dat=%h lat=%0d expected 1 0 13579bdf %0d", r_ack, r_err, r_dat, r_stb_lat, TIMEOUT); end
  endtask

  task automatic test_back_to_back();
    bit exp_e;
    @(negedge clk);
    adr = 32'h0000_0070; we = 1'b0; stb = 1'b1; cyc = 1'b1;
    for (int n = 1; n <= 6; n++) begin
      @(negedge clk);
      exp_e = (n % 2) == 1;
      checks++; if (err !== exp_e || ack !== 1'b0) begin errors++; $display("FAIL b2b_gap[%0d]: err=%b ack=%b expected %b 0", n, err, ack, exp_e); end
      if (exp_e) model_err(32'h0000_0070);
    end
    stb = 1'b0; cyc = 1'b0;
    @(negedge clk);
    checks++; if (err_cnt !== 8'(model_cnt) || err !== 1'b0) begin errors++; $display("FAIL b2b_count: cnt=%0d err=%b expected %0d 0", err_cnt, err, model_cnt); end
  endtask

  task automatic test_abort();
    @(negedge clk);
    adr = 32'h0000_0028; we = 1'b0; stb = 1'b1; cyc = 1'b1; s_ack = '0;
    repeat (3) @(negedge clk);
    checks++; if (s_stb !== 4'b0010) begin errors++; $display("FAIL abort_access: stb=%b expected 0010", s_stb); end
    stb = 1'b0; cyc = 1'b0; s_ack = 4'b0010;
    @(negedge clk); s_ack = '0;
    checks++; if (s_stb !== '0 || ack !== 1'b0 || err !== 1'b0) begin errors++; $display("FAIL abort_cyc_drop: stb=%b ack=%b err=%b expected 0 0 0", s_stb, ack, err); end
    @(negedge clk);
    adr = 32'h0000_0038; we = 1'b1; datwr = 32'hCAFE_F00D; stb = 1'b1; cyc = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b1;
    repeat (2) @(negedge clk);
    checks++; if (ack !== 1'b0 || err !== 1'b0 || datrd !== '0 || s_stb !== '0 || s_cyc !== '0) begin errors++; $display("FAIL abort_rst_resp: ack=%b err=%b dat=%h stb=%b expected all 0", ack, err, datrd, s_stb); end
    checks++; if (s_we !== 1'b0 || s_adr !== '0 || s_dat_o !== '0 || err_adr !== '0 || err_cnt !== 8'd0) begin errors++; $display("FAIL abort_rst_state: we=%b adr=%h dat=%h eadr=%h ecnt=%0d expected all 0", s_we, s_adr, s_dat_o, err_adr, err_cnt); end
    stb = 1'b0; cyc = 1'b0; rst = 1'b0; model_cnt = 0; model_eadr = '0;
    run_txn(32'h0000_0020, 1'b0, 32'h0, 1, 32'h0BAD_CAFE, 1'b0, 20);
    checks++; if (!r_ack || r_err || r_dat !== 32'h0BAD_CAFE || r_lat !== 2) begin errors++; $display("FAIL abort_recover: ack=%b err=%b dat=%h lat=%0d expected 1 0 0badcafe 2", r_ack, r_err, r_dat, r_lat); end
  endtask

  task automatic test_saturation();
    logic [BUSW-1:0] a;
    int bad;
    bad = 0;
    for (int i = 0; i < 300; i++) begin
      a = ($urandom_range(0, 3) == 0) ? BUSW'($urandom_range(0, 15)) : (BUSW'($urandom_range(5, 4095)) << PAGE_LSB);
      run_txn(a, 1'($urandom_range(0, 1)), $urandom, 1, 32'h0, 1'b1, 10);
      model_err(a);
      checks++; if (!r_err || r_ack || r_lat !== 1) begin errors++; bad++; if (bad < 5) $display("FAIL sat_unmapped[%0d]: err=%b ack=%b lat=%0d expected 1 0 1", i, r_err, r_ack, r_lat); end
    end
    checks++; if (err_cnt !== 8'(model_cnt) || err_cnt !== 8'd255) begin errors++; $display("FAIL sat_count: got %0d expected %0d", err_cnt, model_cnt); end
    checks++; if (err_adr !== model_eadr) begin errors++; $display("FAIL sat_erradr: got %h expected %h", err_adr, model_eadr); end
  endtask

  initial begin
    rst = 1'b1; adr = '0; datwr = '0; we = 1'b0; stb = 1'b0; cyc = 1'b0; s_ack = '0; s_dat = '0;
    test_reset();
    test_directed();
    test_random();
    test_timeout();
    test_back_to_back();
    test_abort();
    test_saturation();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
